alu_issue_fifo: RTL and testbench

ALU_ISSUE_FIFO -- requirements
Module: alu_issue_fifo

---
 rtl/alu_issue_fifo.sv | 158 +++++++++++++++
 tb/tb_alu_issue_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_fifo.sv
// ALU issue buffer between decode and the ALU: a small circular FIFO that stores
// operands already resolved from their selects, so the ALU side sees plain data.
package alu_issue_pkg;
    typedef enum logic [6:0] {
        ALU_ADD = 7'd0,
        ALU_SUB = 7'd1,
        ALU_XOR = 7'd2,
        ALU_OR  = 7'd3,
        ALU_AND = 7'd4,
        ALU_SRA = 7'd5,
        ALU_SRL = 7'd6,
        ALU_SLL = 7'd7,
        ALU_LT  = 7'd8,
        ALU_LTU = 7'd9,
        ALU_EQ  = 7'd10,
        ALU_NE  = 7'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_A_REG_A  = 2'd0,
        OP_A_FWD    = 2'd1,
        OP_A_CURRPC = 2'd2,
        OP_A_IMM    = 2'd3
    } op_a_sel_e;

    typedef enum logic {
        OP_B_REG_B = 1'b0,
        OP_B_IMM   = 1'b1
    } op_b_sel_e;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } issue_entry_t;
endpackage

module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int   DEPTH     = 2,
    parameter logic CHERIoTEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,

    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  alu_op_e     alu_operator_i,
    input  op_a_sel_e   op_a_sel_i,
    input  op_b_sel_e   op_b_sel_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_rdata_i,
    input  logic [31:0] rs2_rdata_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  rd_i,

    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output alu_op_e     alu_operator_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    output logic [4:0]  rd_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    issue_entry_t     entries_q [DEPTH];
    issue_entry_t     entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    issue_entry_t new_entry;
    issue_entry_t head;
    logic         push;
    logic         pop;

    // Decode-stage parameter carried for interface symmetry only.
    logic unused_cheriot;
    assign unused_cheriot = CHERIoTEn;

    // Handshake readiness depends on stored occupancy only.
    assign dec_ready_o = (count_q < CNT_DEPTH);
    assign ex_valid_o  = (count_q != '0);
    assign push        = dec_valid_i & dec_ready_o;
    assign pop         = ex_valid_o & ex_ready_i;

    always_comb begin
        new_entry    = '0;
        new_entry.op = alu_operator_i;
        new_entry.rd = rd_i;
        case (op_a_sel_i)
            OP_A_REG_A:  new_entry.a = rs1_rdata_i;
            OP_A_CURRPC: new_entry.a = pc_i;
            default:     new_entry.a = '0;
        endcase
        if (op_b_sel_i == OP_B_REG_B) begin
            new_entry.b = rs2_rdata_i;
        end else begin
            new_entry.b = imm_i;
        end
    end

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = new_entry;
                wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Empty buffer presents an all-zero payload rather than stale storage.
    assign head           = ex_valid_o ? entries_q[rd_ptr_q] : '0;
    assign alu_operator_o = head.op;
    assign operand_a_o    = head.a;
    assign operand_b_o    = head.b;
    assign rd_o           = head.rd;

endmodule

// File: tb/tb_alu_issue_fifo.sv
// Bench for alu_issue_fifo: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_alu_issue_fifo;
    import alu_issue_pkg::*;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        dec_valid_i;
    logic        dec_ready_o;
    alu_op_e     alu_operator_i;
    op_a_sel_e   op_a_sel_i;
    op_b_sel_e   op_b_sel_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_rdata_i;
    logic [31:0] rs2_rdata_i;
    logic [31:0] pc_i;
    logic [4:0]  rd_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    alu_op_e     alu_operator_o;
    logic [31:0] operand_a_o;
    logic [31:0] operand_b_o;
    logic [4:0]  rd_o;

    alu_issue_fifo #(.DEPTH(DEPTH), .CHERIoTEn(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .dec_valid_i    (dec_valid_i),
        .dec_ready_o    (dec_ready_o),
        .alu_operator_i (alu_operator_i),
        .op_a_sel_i     (op_a_sel_i),
        .op_b_sel_i     (op_b_sel_i),
        .imm_i          (imm_i),
        .rs1_rdata_i    (rs1_rdata_i),
        .rs2_rdata_i    (rs2_rdata_i),
        .pc_i           (pc_i),
        .rd_i           (rd_i),
        .ex_valid_o     (ex_valid_o),
        .ex_ready_i     (ex_ready_i),
        .alu_operator_o (alu_operator_o),
        .operand_a_o    (operand_a_o),
        .operand_b_o    (operand_b_o),
        .rd_o           (rd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t       mq[$];
    logic [4:0] obs_rd[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_entry();
        exp_t e;
        e.op = alu_operator_i;
        e.rd = rd_i;
        if (op_a_sel_i == OP_A_REG_A)       e.a = rs1_rdata_i;
        else if (op_a_sel_i == OP_A_CURRPC) e.a = pc_i;
        else                                e.a = 32'h0;
        e.b = (op_b_sel_i == OP_B_REG_B) ? rs2_rdata_i : imm_i;
        return e;
    endfunction

    task automatic check_all();
        exp_t h;
        h = '{op: 7'd0, a: 32'h0, b: 32'h0, rd: 5'd0};
        if (mq.size() != 0) h = mq[0];
        chk("ex_valid", ex_valid_o, mq.size() != 0);
        chk("dec_ready", dec_ready_o, mq.size() < DEPTH);
        chk("alu_op", alu_operator_o, h.op);
        chk("operand_a", operand_a_o, h.a);
        chk("operand_b", operand_b_o, h.b);
        chk("rd", rd_o, h.rd);
    endtask

    // Called at the falling edge; inputs are already set for the coming rising edge.
    task automatic cycle();
        logic do_push, do_pop, do_flush;
        exp_t e;
        check_all();
        do_flush = flush_i;
        do_push  = dec_valid_i && (mq.size() < DEPTH);
        do_pop   = ex_ready_i && (mq.size() != 0);
        e        = model_entry();
        if (ex_valid_o && ex_ready_i) obs_rd.push_back(rd_o);
        @(posedge clk_i);
        if (do_flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        flush_i        = 1'b0;
        dec_valid_i    = 1'b0;
        ex_ready_i     = 1'b0;
        alu_operator_i = ALU_ADD;
        op_a_sel_i     = OP_A_REG_A;
        op_b_sel_i     = OP_B_REG_B;
        imm_i          = 32'h0;
        rs1_rdata_i    = 32'h0;
        rs2_rdata_i    = 32'h0;
        pc_i           = 32'h0;
        rd_i           = 5'd0;
    endtask

    task automatic rand_payload();
        alu_operator_i = alu_op_e'($urandom_range(0, 11));
        op_a_sel_i     = op_a_sel_e'($urandom_range(0, 3));
        op_b_sel_i     = op_b_sel_e'($urandom_range(0, 1));
        imm_i          = $urandom;
        rs1_rdata_i    = $urandom;
        rs2_rdata_i    = $urandom;
        pc_i           = $urandom;
        rd_i           = 5'($urandom_range(0, 31));
    endtask

    task automatic push_rs1(input logic [31:0] v, input logic [4:0] rd);
        rand_payload();
        dec_valid_i = 1'b1;
        op_a_sel_i  = OP_A_REG_A;
        rs1_rdata_i = v;
        rd_i        = rd;
        cycle();
        dec_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ex_valid", ex_valid_o, 1'b0);
        chk("rst_dec_ready", dec_ready_o, 1'b1);
        chk("rst_operand_a", operand_a_o, 32'h0);
        check_all();
        rst_ni = 1'b1;
        @(negedge clk_i);

        // AUIPC-style push: PC and immediate operands, one cycle to valid
        dec_valid_i    = 1'b1;
        alu_operator_i = ALU_ADD;
        op_a_sel_i     = OP_A_CURRPC;
        op_b_sel_i     = OP_B_IMM;
        pc_i           = 32'h8000_0010;
        imm_i          = 32'd4;
        rs1_rdata_i    = 32'hdead_beef;
        rd_i           = 5'd3;
        chk("s1_not_yet_valid", ex_valid_o, 1'b0);
        cycle();
        dec_valid_i = 1'b0;
        chk("s1_ex_valid", ex_valid_o, 1'b1);
        chk("s1_operand_a", operand_a_o, 32'h8000_0010);
        chk("s1_operand_b", operand_b_o, 32'd4);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;
        chk("s1_drained", ex_valid_o, 1'b0);

        // Fill to full with the ALU stalled, then release one entry
        push_rs1(32'h11, 5'd1);
        push_rs1(32'h22, 5'd2);
        chk("s2_full_ready", dec_ready_o, 1'b0);
        chk("s2_head_a", operand_a_o, 32'h11);
        dec_valid_i = 1'b1;
        rs1_rdata_i = 32'h33;
        cycle();
        dec_valid_i = 1'b0;
        chk("s2_head_stable", operand_a_o, 32'h11);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;
        chk("s2_next_head_a", operand_a_o, 32'h22);
        chk("s2_ready_again", dec_ready_o, 1'b1);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;

        // Streaming: push and pop every cycle, order preserved, never fills
        obs_rd.delete();
        ex_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            rand_payload();
            dec_valid_i = 1'b1;
            rd_i        = 5'(i);
            cycle();
            chk("s3_ready", dec_ready_o, 1'b1);
        end
        dec_valid_i = 1'b0;
        cycle();
        ex_ready_i = 1'b0;
        chk("s3_count", obs_rd.size(), 32'd8);
        for (int i = 0; i < obs_rd.size() && i < 8; i++) begin
            chk("s3_rd_order", obs_rd[i], 32'(i + 1));
        end
        chk("s3_empty", ex_valid_o, 1'b0);

        // Flush while full with a push offered, then with a push handshaking
        push_rs1(32'hA0, 5'd10);
        push_rs1(32'hA1, 5'd11);
        flush_i     = 1'b1;
        dec_valid_i = 1'b1;
        rd_i        = 5'd12;
        cycle();
        flush_i     = 1'b0;
        dec_valid_i = 1'b0;
        chk("s4_flush_valid", ex_valid_o, 1'b0);
        chk("s4_flush_ready", dec_ready_o, 1'b1);
        push_rs1(32'hB0, 5'd13);
        flush_i = 1'b1;
        push_rs1(32'hB1, 5'd14);
        flush_i = 1'b0;
        chk("s4_push_dropped", ex_valid_o, 1'b0);
        push_rs1(32'hC0, 5'd15);
        chk("s4_fresh_rd", rd_o, 5'd15);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;
        chk("s4_only_entry", ex_valid_o, 1'b0);

        // LUI: immediate in B, zero in A
        dec_valid_i = 1'b1;
        op_a_sel_i  = OP_A_IMM;
        op_b_sel_i  = OP_B_IMM;
        imm_i       = 32'h1234_5000;
        rs1_rdata_i = 32'hffff_ffff;
        cycle();
        dec_valid_i = 1'b0;
        chk("s5_lui_a", operand_a_o, 32'h0);
        chk("s5_lui_b", operand_b_o, 32'h1234_5000);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;

        // Asynchronous reset in the middle of a cycle with one entry held
        push_rs1(32'h77, 5'd7);
        chk("s6_pre_valid", ex_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("s6_rst_valid", ex_valid_o, 1'b0);
        chk("s6_rst_ready", dec_ready_o, 1'b1);
        chk("s6_rst_a", operand_a_o, 32'h0);
        chk("s6_rst_rd", rd_o, 5'd0);
        mq.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        push_rs1(32'h55, 5'd5);
        chk("s6_post_rd", rd_o, 5'd5);
        chk("s6_post_a", operand_a_o, 32'h55);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;
        chk("s6_sole_entry", ex_valid_o, 1'b0);

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 600; n++) begin
            rand_payload();
            dec_valid_i = ($urandom_range(0, 99) < 60);
            ex_ready_i  = ($urandom_range(0, 99) < 50);
            flush_i     = ($urandom_range(0, 99) < 4);
            cycle();
        end
        idle_inputs();
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
